// File: rtl/timer_disp_pkg.sv
// Shared geometry, colour and segment-vector definitions for the kitchen-timer display.
package timer_disp_pkg;

  localparam int CELL_W  = 80;
  localparam int CELL_H  = 160;
  localparam int FIELD_W = 360;

  // Cell origins relative to the left edge of the digit field
  localparam int CELL1_X = 80;
  localparam int COLON_X = 160;
  localparam int CELL2_X = 200;
  localparam int CELL3_X = 280;

  localparam int SEG_UPPER_Y_HI = 73;
  localparam int SEG_G_Y_LO     = 74;
  localparam int SEG_G_Y_HI     = 85;
  localparam int SEG_LOWER_Y_LO = 86;

  localparam int DOT_X_LO  = 14;
  localparam int DOT_X_HI  = 25;
  localparam int DOT1_Y_LO = 40;
  localparam int DOT1_Y_HI = 51;
  localparam int DOT2_Y_LO = 108;
  localparam int DOT2_Y_HI = 119;

  localparam logic [7:0] DEF_FG_COLOR    = 8'b111_111_00;
  localparam logic [7:0] DEF_ALARM_COLOR = 8'b111_000_00;
  localparam logic [7:0] DEF_BG_COLOR    = 8'h00;

  typedef struct packed {
    logic g, f, e, d, c, b, a;
  } seg7_t;

  typedef enum logic [2:0] {
    CELL_D0, CELL_D1, CELL_COLON, CELL_D2, CELL_D3
  } cell_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment map; non-decimal codes show a dash.
module bcd_to_seg7 import timer_disp_pkg::*; (
  input  logic [3:0] i_bcd,
  output seg7_t      o_seg
);

  always_comb begin
    case (i_bcd)            //   gfedcba
      4'd0:    o_seg = seg7_t'(7'b0111111);
      4'd1:    o_seg = seg7_t'(7'b0000110);
      4'd2:    o_seg = seg7_t'(7'b1011011);
      4'd3:    o_seg = seg7_t'(7'b1001111);
      4'd4:    o_seg = seg7_t'(7'b1100110);
      4'd5:    o_seg = seg7_t'(7'b1101101);
      4'd6:    o_seg = seg7_t'(7'b1111101);
      4'd7:    o_seg = seg7_t'(7'b0000111);
      4'd8:    o_seg = seg7_t'(7'b1111111);
      4'd9:    o_seg = seg7_t'(7'b1101111);
      default: o_seg = seg7_t'(7'b1000000);
    endcase
  end

endmodule

// File: rtl/timer_pixel_renderer.sv
// Renders MM:SS as 7-segment digits with alarm flashing; 2-cycle pipeline from
// beam coordinates to rgb, with HS/VS delayed to match.
module timer_pixel_renderer import timer_disp_pkg::*; #(
  parameter int         X0           = 140,
  parameter int         Y0           = 160,
  parameter int         SEG_T        = 12,
  parameter logic [7:0] FG_COLOR     = DEF_FG_COLOR,
  parameter logic [7:0] ALARM_COLOR  = DEF_ALARM_COLOR,
  parameter logic [7:0] BG_COLOR     = DEF_BG_COLOR,
  parameter int         BLINK_FRAMES = 30,
  parameter int         VLINES       = 480
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic [10:0] hcounter,
  input  logic [10:0] vcounter,
  input  logic        blank,
  input  logic        HS,
  input  logic        VS,
  input  logic [3:0]  min_tens,
  input  logic [3:0]  min_ones,
  input  logic [3:0]  sec_tens,
  input  logic [3:0]  sec_ones,
  input  logic        alarm,
  output logic [7:0]  rgb,
  output logic        HS_out,
  output logic        VS_out
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0] LX_T   = 7'(SEG_T);
  localparam logic [6:0] LX_HI  = 7'(CELL_W - 1 - SEG_T);
  localparam logic [6:0] LX_R   = 7'(CELL_W - SEG_T);
  localparam logic [7:0] LY_T   = 8'(SEG_T);
  localparam logic [7:0] LY_D   = 8'(CELL_H - SEG_T);
  localparam logic [7:0] LY_CHI = 8'(CELL_H - 1 - SEG_T);

  logic [3:0] r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
  logic [CW-1:0] r_frame_cnt;
  logic       r_phase;

  cell_t      r_cell;
  logic [6:0] r_lx;
  logic [7:0] r_ly;
  logic       r_in_field, r_blank, r_hs, r_vs;

  logic        w_latch;
  logic [10:0] w_dx;
  logic [7:0]  w_ly;
  logic [6:0]  w_lx;
  cell_t       w_cell;
  logic        w_in_field;

  assign w_latch    = (hcounter == 11'd0) && (vcounter == 11'(VLINES));
  assign w_dx       = hcounter - 11'(X0);
  assign w_ly       = 8'(vcounter - 11'(Y0));
  assign w_in_field = (hcounter >= 11'(X0)) && (hcounter <= 11'(X0 + FIELD_W - 1)) &&
                      (vcounter >= 11'(Y0)) && (vcounter <= 11'(Y0 + CELL_H - 1));

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_cell = CELL_D3;
    w_lx   = 7'(w_dx - 11'(CELL3_X));
    if (w_dx < 11'(CELL1_X)) begin
      w_cell = CELL_D0;
      w_lx   = 7'(w_dx);
    end else if (w_dx < 11'(COLON_X)) begin
      w_cell = CELL_D1;
      w_lx   = 7'(w_dx - 11'(CELL1_X));
    end else if (w_dx < 11'(CELL2_X)) begin
      w_cell = CELL_COLON;
      w_lx   = 7'(w_dx - 11'(COLON_X));
    end else if (w_dx < 11'(CELL3_X)) begin
      w_cell = CELL_D2;
      w_lx   = 7'(w_dx - 11'(CELL2_X));
    end
  end

  // NOTE: reset is sampled synchronously, so rst_n stays out of the sensitivity list;
  // sequential state uses non-blocking assignments only.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_min_tens  <= '0;
      r_min_ones  <= '0;
      r_sec_tens  <= '0;
      r_sec_ones  <= '0;
      r_frame_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      if (w_latch) begin
        r_min_tens <= min_tens;
        r_min_ones <= min_ones;
        r_sec_tens <= sec_tens;
        r_sec_ones <= sec_ones;
      end
      if (!alarm) begin
        r_frame_cnt <= '0;
        r_phase     <= 1'b0;
      end else if (w_latch) begin
        if (r_frame_cnt == CW'(BLINK_FRAMES - 1)) begin
          r_frame_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_cell     <= CELL_D0;
      r_lx       <= '0;
      r_ly       <= '0;
      r_in_field <= 1'b0;
      r_blank    <= 1'b1;
      r_hs       <= 1'b1;
      r_vs       <= 1'b1;
    end else begin
      r_cell     <= w_cell;
      r_lx       <= w_lx;
      r_ly       <= w_ly;
      r_in_field <= w_in_field;
      r_blank    <= blank;
      r_hs       <= HS;
      r_vs       <= VS;
    end
  end

  logic [3:0] w_digit;
  seg7_t      w_seg, w_hit;
  logic       w_mid, w_left, w_right, w_upper, w_lower, w_dot, w_lit;
  logic [7:0] w_fg;

  always_comb begin
    case (r_cell)
      CELL_D0: w_digit = r_min_tens;
      CELL_D1: w_digit = r_min_ones;
      CELL_D2: w_digit = r_sec_tens;
      default: w_digit = r_sec_ones;
    endcase
  end

  bcd_to_seg7 u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg)
  );

  assign w_mid   = (r_lx >= LX_T) && (r_lx <= LX_HI);
  assign w_left  = (r_lx < LX_T);
  assign w_right = (r_lx >= LX_R);
  assign w_upper = (r_ly >= LY_T) && (r_ly <= 8'(SEG_UPPER_Y_HI));
  assign w_lower = (r_ly >= 8'(SEG_LOWER_Y_LO)) && (r_ly <= LY_CHI);

  always_comb begin
    w_hit.a = w_mid && (r_ly < LY_T);
    w_hit.b = w_right && w_upper;
    w_hit.c = w_right && w_lower;
    w_hit.d = w_mid && (r_ly >= LY_D);
    w_hit.e = w_left && w_lower;
    w_hit.f = w_left && w_upper;
    w_hit.g = w_mid && (r_ly >= 8'(SEG_G_Y_LO)) && (r_ly <= 8'(SEG_G_Y_HI));
  end

  assign w_dot = (r_lx >= 7'(DOT_X_LO)) && (r_lx <= 7'(DOT_X_HI)) &&
                 (((r_ly >= 8'(DOT1_Y_LO)) && (r_ly <= 8'(DOT1_Y_HI))) ||
                  ((r_ly >= 8'(DOT2_Y_LO)) && (r_ly <= 8'(DOT2_Y_HI))));
  assign w_lit = r_in_field && ((r_cell == CELL_COLON) ? w_dot : |(w_seg & w_hit));
  assign w_fg  = r_phase ? ALARM_COLOR : FG_COLOR;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      rgb    <= 8'h00;
      HS_out <= 1'b1;
      VS_out <= 1'b1;
    end else begin
      rgb    <= r_blank ? 8'h00 : (w_lit ? w_fg : BG_COLOR);
      HS_out <= r_hs;
      VS_out <= r_vs;
    end
  end

endmodule

// File: tb/tb_timer_pixel_renderer.sv
// Directed bench for timer_pixel_renderer: pixel table plus hand-written
// sequences for latching, blink, sync alignment and mid-line reset.
module tb_timer_pixel_renderer;

  logic        pixel_clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcounter, vcounter;
  logic        blank, HS, VS;
  logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
  logic        alarm;
  logic [7:0]  rgb;
  logic        HS_out, VS_out;

  int n_checks = 0;
  int n_fail   = 0;

  timer_pixel_renderer dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .hcounter  (hcounter),
    .vcounter  (vcounter),
    .blank     (blank),
    .HS        (HS),
    .VS        (VS),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .alarm     (alarm),
    .rgb       (rgb),
    .HS_out    (HS_out),
    .VS_out    (VS_out)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        bl;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int h, input int v, input logic bl,
                              input logic [7:0] exp, input string name);
    vec_t r;
    r.h = 11'(h); r.v = 11'(v); r.bl = bl; r.exp = exp; r.name = name;
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic pix(input int h, input int v, input logic bl,
                     input logic [7:0] exp, input string name);
    hcounter = 11'(h);
    vcounter = 11'(v);
    blank    = bl;
    tick();
    tick();
    check(name, rgb, exp);
  endtask

  task automatic frame_latch();
    hcounter = 11'd0;
    vcounter = 11'd480;
    blank    = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; blank = 1'b1; HS = 1'b0; VS = 1'b0; alarm = 1'b0;
    hcounter = 11'd700; vcounter = 11'd300;
    min_tens = 4'd1; min_ones = 4'd2; sec_tens = 4'd3; sec_ones = 4'd4;
    tick(); tick(); tick();
    check("reset_rgb", rgb, 8'h00);
    check("reset_hs", {7'd0, HS_out}, 8'h01);
    check("reset_vs", {7'd0, VS_out}, 8'h01);
    HS = 1'b1; VS = 1'b1;
    rst_n = 1'b1;
    frame_latch();
    frame_latch();

    // Digits 1,2,3,4 on the field
    vecs.push_back(mk(180, 165, 1'b0, 8'h00, "c0_a_digit1_off"));
    vecs.push_back(mk(215, 190, 1'b0, 8'hFC, "c0_b_on"));
    vecs.push_back(mk(145, 190, 1'b0, 8'h00, "c0_f_off"));
    vecs.push_back(mk(260, 165, 1'b0, 8'hFC, "c1_a_on"));
    vecs.push_back(mk(260, 171, 1'b0, 8'hFC, "c1_a_last_row"));
    vecs.push_back(mk(260, 172, 1'b0, 8'h00, "c1_below_a"));
    vecs.push_back(mk(260, 240, 1'b0, 8'hFC, "c1_g_on"));
    vecs.push_back(mk(295, 260, 1'b0, 8'h00, "c1_c_off"));
    vecs.push_back(mk(225, 260, 1'b0, 8'hFC, "c1_e_on"));
    vecs.push_back(mk(260, 315, 1'b0, 8'hFC, "c1_d_on"));
    vecs.push_back(mk(260, 319, 1'b0, 8'hFC, "c1_d_bottom_row"));
    vecs.push_back(mk(260, 320, 1'b0, 8'h00, "below_field"));
    vecs.push_back(mk(220, 160, 1'b0, 8'h00, "c1_corner"));
    vecs.push_back(mk(320, 205, 1'b0, 8'hFC, "colon_dot_top"));
    vecs.push_back(mk(320, 275, 1'b0, 8'hFC, "colon_dot_bottom"));
    vecs.push_back(mk(320, 240, 1'b0, 8'h00, "colon_gap"));
    vecs.push_back(mk(330, 205, 1'b0, 8'h00, "colon_right_of_dot"));
    vecs.push_back(mk(345, 260, 1'b0, 8'h00, "c2_e_off"));
    vecs.push_back(mk(415, 260, 1'b0, 8'hFC, "c2_c_on"));
    vecs.push_back(mk(460, 165, 1'b0, 8'h00, "c3_a_off"));
    vecs.push_back(mk(425, 190, 1'b0, 8'hFC, "c3_f_on"));
    vecs.push_back(mk(460, 315, 1'b0, 8'h00, "c3_d_off"));
    vecs.push_back(mk(499, 190, 1'b0, 8'hFC, "c3_b_last_col"));
    vecs.push_back(mk(500, 190, 1'b0, 8'h00, "right_of_field"));
    vecs.push_back(mk(139, 190, 1'b0, 8'h00, "left_of_field"));
    vecs.push_back(mk(100, 200, 1'b0, 8'h00, "outside_bg"));
    vecs.push_back(mk(260, 165, 1'b1, 8'h00, "blank_forces_zero"));
    foreach (vecs[i]) pix(vecs[i].h, vecs[i].v, vecs[i].bl, vecs[i].exp, vecs[i].name);

    // Mid-frame digit change must not tear
    pix(180, 240, 1'b0, 8'h00, "tear_before_change");
    min_tens = 4'd8;
    pix(180, 240, 1'b0, 8'h00, "tear_old_g_kept");
    pix(145, 260, 1'b0, 8'h00, "tear_old_e_kept");
    frame_latch();
    pix(180, 240, 1'b0, 8'hFC, "next_frame_new_g");

    // Digit change coincident with the latch event is captured
    hcounter = 11'd0; vcounter = 11'd480; blank = 1'b1; min_tens = 4'd1;
    tick();
    pix(180, 240, 1'b0, 8'h00, "simul_latch_g_off");
    pix(215, 190, 1'b0, 8'hFC, "simul_latch_b_on");

    // HS/VS delayed by exactly two cycles
    blank = 1'b1; vcounter = 11'd300; hcounter = 11'd639; HS = 1'b1; VS = 1'b1;
    tick(); tick();
    for (int k = 640; k <= 760; k++) begin
      hcounter = 11'(k);
      HS = !(k >= 648 && k <= 743);
      VS = !(k >= 690 && k <= 699);
      tick();
      check($sformatf("hs_delay_h%0d", k), {7'd0, HS_out},
            {7'd0, !((k - 1) >= 648 && (k - 1) <= 743)});
      check($sformatf("vs_delay_h%0d", k), {7'd0, VS_out},
            {7'd0, !((k - 1) >= 690 && (k - 1) <= 699)});
    end
    HS = 1'b1; VS = 1'b1;

    // Alarm blink: phase toggles every 30 latch events
    alarm = 1'b1;
    for (int f = 0; f <= 45; f++) begin
      pix(260, 165, 1'b0, (((f / 30) % 2) == 1) ? 8'hE0 : 8'hFC, $sformatf("blink_f%0d", f));
      frame_latch();
    end
    alarm = 1'b0;
    frame_latch();
    pix(260, 165, 1'b0, 8'hFC, "alarm_dropped");

    // Non-decimal digit renders as a dash
    min_tens = 4'hB;
    frame_latch();
    pix(180, 165, 1'b0, 8'h00, "dash_a_off");
    pix(180, 240, 1'b0, 8'hFC, "dash_g_on");
    pix(215, 190, 1'b0, 8'h00, "dash_b_off");
    pix(145, 190, 1'b0, 8'h00, "dash_f_off");

    // Reset in the middle of a visible line
    HS = 1'b0; VS = 1'b0;
    pix(260, 165, 1'b0, 8'hFC, "pre_reset_pixel");
    check("pre_reset_hs_low", {7'd0, HS_out}, 8'h00);
    rst_n = 1'b0;
    tick();
    check("midline_reset_rgb", rgb, 8'h00);
    check("midline_reset_hs", {7'd0, HS_out}, 8'h01);
    check("midline_reset_vs", {7'd0, VS_out}, 8'h01);
    rst_n = 1'b1; HS = 1'b1; VS = 1'b1;
    pix(260, 165, 1'b0, 8'hFC, "post_reset_zero_a");
    pix(260, 240, 1'b0, 8'h00, "post_reset_zero_no_g");
    pix(180, 240, 1'b0, 8'h00, "post_reset_c0_no_g");
    frame_latch();
    pix(180, 240, 1'b0, 8'hFC, "relatch_dash_g");
    pix(260, 240, 1'b0, 8'hFC, "relatch_two_g");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
